// File: rtl/fpdiv_arbiter.sv
// fpdiv_arbiter: round-robin front end that shares one combinational fpdiv
// among NUM_REQ requesters. One divide is in flight at a time. The operands
// are held on fpdiv for SETTLE_CYCLES cycles, and then the quotient is
// captured and returned on a tagged response channel.
module fpdiv_arbiter #(
  parameter int NUM_REQ       = 4,
  parameter int SETTLE_CYCLES = 2,
  parameter int ID_W          = $clog2(NUM_REQ)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_REQ-1:0]    req_valid,
  output logic [NUM_REQ-1:0]    req_ready,
  input  logic [NUM_REQ*32-1:0] req_a,
  input  logic [NUM_REQ*32-1:0] req_b,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [31:0]           resp_result,
  output logic [ID_W-1:0]       resp_id,
  output logic                  resp_dz,
  output logic [31:0]           div_a,
  output logic [31:0]           div_b,
  input  logic [31:0]           div_result,
  output logic                  busy
);

  // The counter only ever holds values up to SETTLE_CYCLES-1.
  localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t          state_q;
  logic [ID_W-1:0] rr_ptr_q;
  logic [CNT_W-1:0] cnt_q;
  logic            resp_valid_q;
  logic [31:0]     resp_result_q;
  logic [ID_W-1:0] resp_id_q;
  logic            resp_dz_q;
  logic [31:0]     div_a_q;
  logic [31:0]     div_b_q;

  logic            grant_found;
  logic [ID_W-1:0] grant_idx;
  logic [31:0]     grant_a;
  logic [31:0]     grant_b;
  logic            accept;
  logic [ID_W-1:0] rr_ptr_d;
  int              scan_idx;

  // Circular priority scan starting at rr_ptr_q. The loop walks the offsets
  // from the far end so that the nearest valid requester is written last
  // and therefore wins.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    grant_a     = '0;
    grant_b     = '0;
    scan_idx    = 0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      scan_idx = (int'(rr_ptr_q) + k) % NUM_REQ;
      if (req_valid[scan_idx]) begin
        grant_found = 1'b1;
        grant_idx   = ID_W'(scan_idx);
        grant_a     = req_a[scan_idx*32 +: 32];
        grant_b     = req_b[scan_idx*32 +: 32];
      end
    end
  end

  // Requests are only accepted in IDLE. Reset gates ready off combinationally
  // so that nothing handshakes during the reset cycle.
  assign accept    = rst_n && (state_q == S_IDLE) && grant_found;
  assign req_ready = accept ? (NUM_REQ'(1) << grant_idx) : '0;

  // The pointer moves to the slot after the granted one, wrapping at NUM_REQ.
  assign rr_ptr_d = (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;

  // Sequencer: accept -> settle on fpdiv -> hold the response until consumed.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      rr_ptr_q      <= '0;
      cnt_q         <= '0;
      resp_valid_q  <= 1'b0;
      resp_result_q <= '0;
      resp_id_q     <= '0;
      resp_dz_q     <= 1'b0;
      div_a_q       <= '0;
      div_b_q       <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            div_a_q   <= grant_a;
            div_b_q   <= grant_b;
            resp_id_q <= grant_idx;
            resp_dz_q <= (grant_b[30:0] == 31'd0);
            rr_ptr_q  <= rr_ptr_d;
            cnt_q     <= CNT_W'(SETTLE_CYCLES - 1);
            state_q   <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (cnt_q == '0) begin
            resp_result_q <= div_result;
            resp_valid_q  <= 1'b1;
            state_q       <= S_RESP;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        S_RESP: begin
          if (resp_ready) begin
            resp_valid_q <= 1'b0;
            state_q      <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign resp_valid  = resp_valid_q;
  assign resp_result = resp_result_q;
  assign resp_id     = resp_id_q;
  assign resp_dz     = resp_dz_q;
  assign div_a       = div_a_q;
  assign div_b       = div_b_q;
  assign busy        = (state_q != S_IDLE);

endmodule

// File: tb/tb_fpdiv_arbiter.sv
// Directed bench for fpdiv_arbiter. A stand-in for fpdiv is modelled here as
// a scrambling function of the two operands. Its output is registered, so it
// only becomes correct one cycle after the operands change, and this makes a
// capture taken before the settle time detectable.
module tb_fpdiv_arbiter;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [3:0]   req_valid;
  logic [3:0]   req_ready;
  logic [127:0] req_a;
  logic [127:0] req_b;
  logic         resp_valid;
  logic         resp_ready;
  logic [31:0]  resp_result;
  logic [1:0]   resp_id;
  logic         resp_dz;
  logic [31:0]  div_a;
  logic [31:0]  div_b;
  logic [31:0]  div_result;
  logic [31:0]  div_q;
  logic         busy;

  int errors = 0;
  int checks = 0;

  fpdiv_arbiter dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_a       (req_a),
    .req_b       (req_b),
    .resp_valid  (resp_valid),
    .resp_ready  (resp_ready),
    .resp_result (resp_result),
    .resp_id     (resp_id),
    .resp_dz     (resp_dz),
    .div_a       (div_a),
    .div_b       (div_b),
    .div_result  (div_result),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] fmodel(input logic [31:0] a, input logic [31:0] b);
    return (a + {b[7:0], b[31:8]}) ^ 32'h5A5A_0000;
  endfunction

  always @(posedge clk) div_q <= fmodel(div_a, div_b);
  assign div_result = div_q;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ops(input int i, input logic [31:0] a, input logic [31:0] b);
    req_a[i*32 +: 32] = a;
    req_b[i*32 +: 32] = b;
  endtask

  // One operation with resp_ready held high. The bench is in IDLE at entry.
  task automatic run_op(input int g, input logic [31:0] a, input logic [31:0] b,
                        input bit drop_valid);
    #1;
    chk("grant_onehot", 32'(req_ready), 32'(4'b0001 << g));
    step();
    chk("busy_after_accept", 32'(busy), 32'd1);
    chk("ready_low_in_wait", 32'(req_ready), 32'd0);
    chk("div_a_latched", div_a, a);
    chk("div_b_latched", div_b, b);
    if (drop_valid) req_valid[g] = 1'b0;
    step();
    chk("no_resp_early", 32'(resp_valid), 32'd0);
    step();
    chk("resp_valid_at_latency", 32'(resp_valid), 32'd1);
    chk("resp_result", resp_result, fmodel(a, b));
    chk("resp_id", 32'(resp_id), 32'(g));
    chk("resp_dz", 32'(resp_dz), 32'(b[30:0] == 31'd0));
    step();
    chk("resp_consumed", 32'(resp_valid), 32'd0);
    chk("idle_after_resp", 32'(busy), 32'd0);
  endtask

  logic [31:0] hold_exp;

  initial begin
    rst_n      = 1'b0;
    req_valid  = 4'hF;
    req_a      = '0;
    req_b      = '0;
    resp_ready = 1'b0;

    // Reset state. All requesters are valid, yet ready must stay low.
    step();
    step();
    chk("rst_ready", 32'(req_ready), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_resp_result", resp_result, 32'd0);
    chk("rst_resp_id", 32'(resp_id), 32'd0);
    chk("rst_resp_dz", 32'(resp_dz), 32'd0);
    chk("rst_div_a", div_a, 32'd0);
    chk("rst_div_b", div_b, 32'd0);

    // Single request from requester 0.
    req_valid = 4'h0;
    rst_n     = 1'b1;
    step();
    chk("idle_no_ready", 32'(req_ready), 32'd0);
    resp_ready = 1'b1;
    set_ops(0, 32'h3F28F5C3, 32'h3F028F5C);
    req_valid = 4'b0001;
    run_op(0, 32'h3F28F5C3, 32'h3F028F5C, 1'b1);

    // All four requesters valid immediately after reset: grants go 0,1,2,3.
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    set_ops(0, 32'h40000000, 32'h3F800000);
    set_ops(1, 32'h40400000, 32'h40000000);
    set_ops(2, 32'hC0A00000, 32'h40800000);
    set_ops(3, 32'h41200000, 32'h40400000);
    req_valid = 4'hF;
    run_op(0, 32'h40000000, 32'h3F800000, 1'b1);
    run_op(1, 32'h40400000, 32'h40000000, 1'b1);
    run_op(2, 32'hC0A00000, 32'h40800000, 1'b1);
    run_op(3, 32'h41200000, 32'h40400000, 1'b1);

    // Requesters 1 and 3 are held valid continuously and must alternate.
    set_ops(1, 32'h3F800000, 32'h40E00000);
    set_ops(3, 32'h42C80000, 32'h41000000);
    req_valid = 4'b1010;
    for (int n = 0; n < 3; n++) begin
      run_op(1, 32'h3F800000, 32'h40E00000, 1'b0);
      run_op(3, 32'h42C80000, 32'h41000000, 1'b0);
    end
    req_valid = 4'h0;

    // Backpressure: the response is held for 5 cycles. The pointer is at 0
    // here, so requester 2 is the only candidate.
    resp_ready = 1'b0;
    set_ops(2, 32'h3E800000, 32'h3F400000);
    req_valid = 4'b0100;
    #1;
    chk("bp_grant", 32'(req_ready), 32'b0100);
    step();
    req_valid = 4'h0;
    step();
    step();
    hold_exp  = fmodel(32'h3E800000, 32'h3F400000);
    req_valid = 4'hF;
    for (int n = 0; n < 5; n++) begin
      #1;
      chk("bp_valid_held", 32'(resp_valid), 32'd1);
      chk("bp_result_held", resp_result, hold_exp);
      chk("bp_id_held", 32'(resp_id), 32'd2);
      chk("bp_no_ready", 32'(req_ready), 32'd0);
      step();
    end
    req_valid  = 4'h0;
    resp_ready = 1'b1;
    step();
    chk("bp_released", 32'(resp_valid), 32'd0);
    chk("bp_idle", 32'(busy), 32'd0);

    // Divisor of -0 from requester 3; the pointer now sits at 3.
    set_ops(3, 32'h3F800000, 32'h80000000);
    req_valid = 4'b1000;
    run_op(3, 32'h3F800000, 32'h80000000, 1'b1);

    // Reset during WAIT drops the operation and returns the pointer to 0.
    set_ops(1, 32'h40800000, 32'h40000000);
    req_valid = 4'b0010;
    #1;
    chk("mid_grant", 32'(req_ready), 32'b0010);
    step();
    chk("mid_in_wait", 32'(busy), 32'd1);
    req_valid = 4'h0;
    rst_n     = 1'b0;
    step();
    rst_n = 1'b1;
    chk("mid_rst_idle", 32'(busy), 32'd0);
    for (int n = 0; n < 4; n++) begin
      chk("mid_no_resp", 32'(resp_valid), 32'd0);
      step();
    end
    set_ops(0, 32'h41000000, 32'h40800000);
    set_ops(2, 32'h41100000, 32'h40400000);
    req_valid = 4'b0101;
    run_op(0, 32'h41000000, 32'h40800000, 1'b1);
    req_valid = 4'h0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
